// File: rtl/uart_pwm_pkg.sv
// Shared constants and types for the UART command path feeding the PWM generator.
package uart_pwm_pkg;

  localparam logic [7:0] AsciiCr  = 8'h0D;
  localparam logic [7:0] AsciiLf  = 8'h0A;
  localparam logic [7:0] AsciiFUp = 8'h46;
  localparam logic [7:0] AsciiFLo = 8'h66;
  localparam logic [7:0] AsciiDUp = 8'h44;
  localparam logic [7:0] AsciiDLo = 8'h64;
  localparam logic [7:0] Ascii0   = 8'h30;
  localparam logic [7:0] Ascii9   = 8'h39;

  localparam int unsigned DutyMax = 100;

  typedef enum logic [1:0] {
    StIdle,
    StGetF,
    StGetD,
    StDiscard
  } state_e;

  function automatic logic is_term(input logic [7:0] b);
    return (b == AsciiCr) || (b == AsciiLf);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= Ascii0) && (b <= Ascii9);
  endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal accumulator: value = value*10 + digit per accepted digit, with sticky overflow
// on either value width or digit count.
module dec_accum #(
  parameter int unsigned Width     = 32,
  parameter int unsigned MaxDigits = 10,
  parameter int unsigned NdigW     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  output logic [Width-1:0] value,
  output logic [NdigW-1:0] ndig,
  output logic             ovf
);

  logic [Width-1:0] value_q;
  logic [NdigW-1:0] ndig_q;
  logic             ovf_q;
  logic [Width+3:0] prod;
  logic             ndig_full;

  // x10 as shift-and-add in a widened datapath so the carry-out is observable
  assign prod = ({4'b0000, value_q} << 3) + ({4'b0000, value_q} << 1)
              + {{Width{1'b0}}, digit};
  assign ndig_full = (ndig_q == NdigW'(MaxDigits));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value_q <= '0;
      ndig_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (digit_valid) begin
      value_q <= prod[Width-1:0];
      if (!ndig_full) begin
        ndig_q <= ndig_q + 1'b1;
      end
      if ((prod[Width+3:Width] != 4'd0) || ndig_full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign value = value_q;
  assign ndig  = ndig_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses "F<dec>" / "D<dec>" lines from the UART byte stream, commits PWM frequency/duty and
// emits one OK/ERR response per terminated non-empty line.
module uart_cmd_ctrl
  import uart_pwm_pkg::*;
#(
  parameter int unsigned FREQ_W       = 32,
  parameter int unsigned FREQ_DEFAULT = 1000,
  parameter int unsigned FREQ_MAX     = 100000,
  parameter int unsigned DUTY_DEFAULT = 50,
  parameter int unsigned MAX_DIGITS   = 10
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [FREQ_W-1:0] freq_hz,
  output logic [6:0]        duty_pct,
  output logic              cfg_update,
  output logic              resp_valid,
  output logic              resp_ok,
  output logic              busy
);

  localparam int unsigned NdigW = $clog2(MAX_DIGITS + 1);

  state_e            state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [6:0]        duty_q, duty_d;
  logic              cfg_update_q, cfg_update_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_ok_q, resp_ok_d;

  logic              acc_clear;
  logic              acc_digit_valid;
  logic [FREQ_W-1:0] acc_value;
  logic [NdigW-1:0]  acc_ndig;
  logic              acc_ovf;
  logic              acc_good;
  logic              freq_ok;
  logic              duty_ok;

  dec_accum #(
    .Width    (FREQ_W),
    .MaxDigits(MAX_DIGITS),
    .NdigW    (NdigW)
  ) u_dec_accum (
    .clk        (clk_50mhz),
    .rst        (rst),
    .clear      (acc_clear),
    .digit_valid(acc_digit_valid),
    .digit      (rx_data[3:0]),
    .value      (acc_value),
    .ndig       (acc_ndig),
    .ovf        (acc_ovf)
  );

  assign acc_good = (acc_ndig != '0) && !acc_ovf;
  assign freq_ok  = acc_good && (acc_value != '0) && (acc_value <= FREQ_W'(FREQ_MAX));
  assign duty_ok  = acc_good && (acc_value <= FREQ_W'(DutyMax));

  always_comb begin
    state_d         = state_q;
    freq_d          = freq_q;
    duty_d          = duty_q;
    cfg_update_d    = 1'b0;
    resp_valid_d    = 1'b0;
    resp_ok_d       = 1'b0;
    acc_clear       = 1'b0;
    acc_digit_valid = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == AsciiFUp || rx_data == AsciiFLo) begin
            state_d   = StGetF;
            acc_clear = 1'b1;
          end else if (rx_data == AsciiDUp || rx_data == AsciiDLo) begin
            state_d   = StGetD;
            acc_clear = 1'b1;
          end else if (!is_term(rx_data)) begin
            state_d = StDiscard;
          end
        end
        StGetF, StGetD: begin
          if (is_digit(rx_data)) begin
            acc_digit_valid = 1'b1;
          end else if (is_term(rx_data)) begin
            state_d      = StIdle;
            resp_valid_d = 1'b1;
            if (state_q == StGetF) begin
              if (freq_ok) begin
                resp_ok_d    = 1'b1;
                freq_d       = acc_value;
                cfg_update_d = (acc_value != freq_q);
              end
            end else if (duty_ok) begin
              resp_ok_d    = 1'b1;
              duty_d       = acc_value[6:0];
              cfg_update_d = (acc_value[6:0] != duty_q);
            end
          end else begin
            state_d = StDiscard;
          end
        end
        StDiscard: begin
          if (is_term(rx_data)) begin
            state_d      = StIdle;
            resp_valid_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q      <= StIdle;
      freq_q       <= FREQ_W'(FREQ_DEFAULT);
      duty_q       <= 7'(DUTY_DEFAULT);
      cfg_update_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      freq_q       <= freq_d;
      duty_q       <= duty_d;
      cfg_update_q <= cfg_update_d;
      resp_valid_q <= resp_valid_d;
      resp_ok_q    <= resp_ok_d;
    end
  end

  assign freq_hz    = freq_q;
  assign duty_pct   = duty_q;
  assign cfg_update = cfg_update_q;
  assign resp_valid = resp_valid_q;
  assign resp_ok    = resp_ok_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: each terminated line pushes its expected response.
module tb_uart_cmd_ctrl;

  logic        clk_50mhz = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] freq_hz;
  logic [6:0]  duty_pct;
  logic        cfg_update;
  logic        resp_valid;
  logic        resp_ok;
  logic        busy;

  typedef struct {
    bit ok;
    bit upd;
    int freq;
    int duty;
    int at;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   exp_freq = 1000;
  int   exp_duty = 50;

  uart_cmd_ctrl u_dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .freq_hz   (freq_hz),
    .duty_pct  (duty_pct),
    .cfg_update(cfg_update),
    .resp_valid(resp_valid),
    .resp_ok   (resp_ok),
    .busy      (busy)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  always @(posedge clk_50mhz) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per response, flags late/missing and stray pulses.
  always @(negedge clk_50mhz) begin
    if (!rst) begin
      if (sb.size() > 0 && cyc > sb[0].at) begin
        check("resp_missing", 64'(cyc), 64'(sb[0].at));
        void'(sb.pop_front());
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", 64'(resp_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_latency", 64'(cyc), 64'(e.at));
          check("resp_ok", 64'(resp_ok), 64'(e.ok));
          check("cfg_update", 64'(cfg_update), 64'(e.upd));
          check("freq_hz", 64'(freq_hz), 64'(e.freq));
          check("duty_pct", 64'(duty_pct), 64'(e.duty));
        end
      end else begin
        check("cfg_update_idle", 64'(cfg_update), 64'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_50mhz);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic finish_bytes();
    @(posedge clk_50mhz);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Sends payload + CR (+ LF); the CR carries the expected response for non-empty lines.
  task automatic send_line(input string s, input bit add_lf, input bit has_resp, input bit ok,
                           input int nf, input int nd);
    exp_t e;
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    send_byte(8'h0D);
    if (has_resp) begin
      e.ok   = ok;
      e.upd  = (nf != exp_freq) || (nd != exp_duty);
      e.freq = nf;
      e.duty = nd;
      e.at   = cyc + 1;
      sb.push_back(e);
      exp_freq = nf;
      exp_duty = nd;
    end
    if (add_lf) send_byte(8'h0A);
    finish_bytes();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk_50mhz);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(2);
    @(negedge clk_50mhz);
    check("rst_freq", 64'(freq_hz), 64'd1000);
    check("rst_duty", 64'(duty_pct), 64'd50);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_ok", 64'(resp_ok), 64'd0);

    send_line("F2500", 1'b0, 1'b1, 1'b1, 2500, exp_duty);
    send_line("d75", 1'b1, 1'b1, 1'b1, exp_freq, 75);
    send_line("D75", 1'b0, 1'b1, 1'b1, exp_freq, 75);
    send_line("", 1'b1, 1'b0, 1'b0, exp_freq, exp_duty);

    send_line("D101", 1'b0, 1'b1, 1'b0, exp_freq, exp_duty);
    send_line("F0", 1'b0, 1'b1, 1'b0, exp_freq, exp_duty);
    send_line("F100001", 1'b0, 1'b1, 1'b0, exp_freq, exp_duty);
    send_line("F", 1'b0, 1'b1, 1'b0, exp_freq, exp_duty);
    send_line("F99999999999", 1'b0, 1'b1, 1'b0, exp_freq, exp_duty);
    send_line("F9999999999", 1'b0, 1'b1, 1'b0, exp_freq, exp_duty);

    send_line("F100000", 1'b0, 1'b1, 1'b1, 100000, exp_duty);
    send_line("f1", 1'b1, 1'b1, 1'b1, 1, exp_duty);
    send_line("D100", 1'b0, 1'b1, 1'b1, exp_freq, 100);
    send_line("D0", 1'b0, 1'b1, 1'b1, exp_freq, 0);

    send_line("X12", 1'b0, 1'b1, 1'b0, exp_freq, exp_duty);
    send_line("F1a2", 1'b0, 1'b1, 1'b0, exp_freq, exp_duty);
    send_line("F500", 1'b1, 1'b1, 1'b1, 500, exp_duty);
    idle_cycles(3);

    // Partial line then reset: no response, defaults back.
    send_byte("F");
    send_byte("1");
    send_byte("2");
    finish_bytes();
    @(negedge clk_50mhz);
    check("busy_mid_line", 64'(busy), 64'd1);
    @(posedge clk_50mhz);
    #1;
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    exp_freq = 1000;
    exp_duty = 50;
    @(negedge clk_50mhz);
    check("rst2_freq", 64'(freq_hz), 64'd1000);
    check("rst2_duty", 64'(duty_pct), 64'd50);
    check("rst2_busy", 64'(busy), 64'd0);
    send_line("D10", 1'b0, 1'b1, 1'b1, exp_freq, 10);

    idle_cycles(5);
    @(negedge clk_50mhz);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("final_freq", 64'(freq_hz), 64'd1000);
    check("final_duty", 64'(duty_pct), 64'd10);
    check("final_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
